// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } div_state_e;

    // Bit-counter width for a given operand width: $clog2(WIDTH), never below 1.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift/subtract step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_c_o,
    output logic             q_bit_c_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Partial remainder stays below the divisor, so the result always fits WIDTH bits.
    always_comb begin
        shifted   = {rem_i, bit_i};
        trial     = shifted - {1'b0, divisor_i};
        rem_c_o   = shifted[WIDTH-1:0];
        q_bit_c_o = 1'b0;
        if (!trial[WIDTH]) begin
            rem_c_o   = trial[WIDTH-1:0];
            q_bit_c_o = 1'b1;
        end
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned divider: one quotient bit per clock with a start/done handshake.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (sr_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_c_o   (step_rem),
        .q_bit_c_o (step_q)
    );

    // Dividend shifts out MSB-first while quotient bits fill in from the LSB.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d  = dividend;
                    dvs_d = divisor;
                    rem_d = '0;
                    if (divisor == '0) begin
                        state_d     = FIN;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CNT_W'(WIDTH - 1);
                    end
                end
            end
            CALC: begin
                sr_d  = {sr_q[WIDTH-2:0], step_q};
                rem_d = step_rem;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d     = FIN;
                    quotient_d  = {sr_q[WIDTH-2:0], step_q};
                    remainder_d = step_rem;
                    dbz_d       = 1'b0;
                    done_d      = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=4) against an arithmetic reference model.
module tb_seq_restoring_divider;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division; edge count includes the start-sampling edge.
    function automatic void model(input int a, input int b, output int q, output int r,
                                  output int z, output int lat);
        if (b == 0) begin
            q = (1 << W) - 1; r = a; z = 1; lat = 1;
        end else begin
            q = a / b; r = a % b; z = 0; lat = W + 1;
        end
    endfunction

    // Issues one operation from IDLE and observes it; leaves the bench #1 after an edge in IDLE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int q, output int r, output int z, output int edges,
                          output int busy_cycles, output bit pulse_ok, output bit hold_ok);
        logic [W-1:0] q0, r0;
        logic         z0;
        q0 = quotient; r0 = remainder; z0 = div_by_zero;
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
        edges = 1; busy_cycles = 0; hold_ok = 1'b1;
        while (done !== 1'b1 && edges < 40) begin
            if (busy === 1'b1) busy_cycles++;
            if (quotient !== q0 || remainder !== r0 || div_by_zero !== z0) hold_ok = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
        if (busy === 1'b1) busy_cycles++;
        q = int'(quotient); r = int'(remainder); z = int'(div_by_zero);
        @(posedge clk); #1;
        pulse_ok = (done === 1'b0) && (busy === 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        #2;
        n_checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int q, r, z, e, bc;
        bit p, h;
        run_op(4'd13, 4'd3, q, r, z, e, bc, p, h);
        n_checks++;
        if (q !== 4 || r !== 1 || z !== 0) begin
            n_fail++; $display("FAIL basic_13_3: got q=%0d r=%0d dbz=%0d, want q=4 r=1 dbz=0", q, r, z);
        end
        n_checks++;
        if (e !== W + 1) begin
            n_fail++; $display("FAIL basic_latency: got %0d edges, want %0d", e, W + 1);
        end
        n_checks++;
        if (bc !== W + 1) begin
            n_fail++; $display("FAIL basic_busy: got busy for %0d cycles, want %0d", bc, W + 1);
        end
        n_checks++;
        if (!p || !h) begin
            n_fail++; $display("FAIL basic_pulse_hold: got pulse_ok=%0d hold_ok=%0d, want 1 1", p, h);
        end
    endtask

    task automatic test_back_to_back();
        int q, r, z, e, bc;
        bit p, h;
        run_op(4'd5, 4'd7, q, r, z, e, bc, p, h);
        n_checks++;
        if (q !== 0 || r !== 5 || e !== W + 1 || !p) begin
            n_fail++; $display("FAIL b2b_first: got q=%0d r=%0d edges=%0d pulse=%0d, want 0 5 %0d 1", q, r, e, p, W + 1);
        end
        run_op(4'd15, 4'd1, q, r, z, e, bc, p, h);
        n_checks++;
        if (q !== 15 || r !== 0 || e !== W + 1 || !p || !h) begin
            n_fail++; $display("FAIL b2b_second: got q=%0d r=%0d edges=%0d pulse=%0d hold=%0d, want 15 0 %0d 1 1", q, r, e, p, h, W + 1);
        end
    endtask

    task automatic test_div_by_zero();
        int q, r, z, e, bc;
        bit p, h;
        run_op(4'd9, 4'd0, q, r, z, e, bc, p, h);
        n_checks++;
        if (q !== 15 || r !== 9 || z !== 1 || e !== 1 || bc !== 1 || !p) begin
            n_fail++; $display("FAIL dbz_9_0: got q=%0d r=%0d dbz=%0d edges=%0d busy=%0d pulse=%0d, want 15 9 1 1 1 1", q, r, z, e, bc, p);
        end
        run_op(4'd6, 4'd2, q, r, z, e, bc, p, h);
        n_checks++;
        if (q !== 3 || r !== 0 || z !== 0 || !h) begin
            n_fail++; $display("FAIL dbz_clear: got q=%0d r=%0d dbz=%0d hold=%0d, want 3 0 0 1", q, r, z, h);
        end
    endtask

    task automatic test_start_ignored();
        int dones, first_done, edge_n;
        start = 1'b1; dividend = 4'd12; divisor = 4'd5;
        @(posedge clk); #1;
        start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
        dones = 0; first_done = 0;
        for (int i = 1; i <= 12; i++) begin
            edge_n = i;
            start = (i == 2);
            if (i == 2) begin dividend = 4'd1; divisor = 4'd1; end
            else begin dividend = W'($urandom); divisor = W'($urandom); end
            if (done === 1'b1) begin
                dones++;
                if (first_done == 0) first_done = edge_n;
                n_checks++;
                if (quotient !== 4'd2 || remainder !== 4'd2) begin
                    n_fail++; $display("FAIL ignore_result: got q=%0d r=%0d, want q=2 r=2", quotient, remainder);
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_checks++;
        if (dones !== 1 || first_done !== W + 1) begin
            n_fail++; $display("FAIL ignore_done_count: got %0d dones (first at edge %0d), want 1 at edge %0d", dones, first_done, W + 1);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL ignore_idle: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_reset_mid_op();
        int q, r, z, e, bc, stray;
        bit p, h;
        start = 1'b1; dividend = 4'd15; divisor = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            n_fail++; $display("FAIL midrst_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
                               busy, done, div_by_zero, quotient, remainder);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        n_checks++;
        if (stray !== 0) begin
            n_fail++; $display("FAIL midrst_no_done: got %0d cycles with done/busy, want 0", stray);
        end
        run_op(4'd15, 4'd2, q, r, z, e, bc, p, h);
        n_checks++;
        if (q !== 7 || r !== 1 || z !== 0 || e !== W + 1) begin
            n_fail++; $display("FAIL midrst_rerun: got q=%0d r=%0d dbz=%0d edges=%0d, want 7 1 0 %0d", q, r, z, e, W + 1);
        end
    endtask

    task automatic test_sweep();
        int q, r, z, e, bc, eq, er, ez, el;
        bit p, h;
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #0;
                run_op(W'(a), W'(b), q, r, z, e, bc, p, h);
                model(a, b, eq, er, ez, el);
                n_checks++;
                if (q !== eq || r !== er || z !== ez) begin
                    n_fail++; $display("FAIL sweep_%0d_%0d: got q=%0d r=%0d dbz=%0d, want q=%0d r=%0d dbz=%0d", a, b, q, r, z, eq, er, ez);
                end
                n_checks++;
                if (e !== el || bc !== el || !p || !h) begin
                    n_fail++; $display("FAIL sweep_timing_%0d_%0d: got edges=%0d busy=%0d pulse=%0d hold=%0d, want %0d %0d 1 1", a, b, e, bc, p, h, el, el);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_by_zero();
        test_start_ignored();
        test_reset_mid_op();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
